// File: rtl/clock_sequencer.sv
// ---------------------------------------------------------------------------
// clock_sequencer: multi-phase machine-cycle generator with run/stop/step. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clock_sequencer #(
  parameter int PHASES      = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int WS_PHASE    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   nstart,
  input  logic                   nstop,
  input  logic                   step,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic                   cdiv,
  output logic                   running,
  output logic [PHASES-1:0]      phase,
  output logic                   sc,
  output logic                   ws,
  output logic [COUNT_WIDTH-1:0] cycles
);

  localparam int                LAST        = SYNC_STAGES - 1;
  localparam logic [PHASES-1:0] PHASE_FIRST = PHASES'(1);

  typedef enum logic [1:0] {
    S_HALT     = 2'd0,
    S_RUN      = 2'd1,
    S_STEP     = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] nstart_sync, nstop_sync, step_sync;
  logic                   nstart_q, nstop_q, step_q;
  logic                   start_edge, stop_edge, step_edge;

  logic [DIV_WIDTH-1:0]   tick, tick_n, div_lat, div_n;
  logic [PHASES-1:0]      phase_n;
  logic                   cdiv_lat, cdiv_n, ws_n;
  logic [COUNT_WIDTH-1:0] cycles_n;
  logic                   phase_end, cycle_end, enter, advance, halt;

  // Panel inputs are asynchronous; idle levels are held through reset so release is edge-free.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nstart_sync <= '1;
      nstop_sync  <= '1;
      step_sync   <= '0;
      nstart_q    <= 1'b1;
      nstop_q     <= 1'b1;
      step_q      <= 1'b0;
    end else begin
      nstart_sync <= {nstart_sync[SYNC_STAGES-2:0], nstart};
      nstop_sync  <= {nstop_sync[SYNC_STAGES-2:0], nstop};
      step_sync   <= {step_sync[SYNC_STAGES-2:0], step};
      nstart_q    <= nstart_sync[LAST];
      nstop_q     <= nstop_sync[LAST];
      step_q      <= step_sync[LAST];
    end
  end

  assign start_edge = nstart_q & ~nstart_sync[LAST];
  assign stop_edge  = nstop_q & ~nstop_sync[LAST];
  assign step_edge  = ~step_q & step_sync[LAST];

  assign phase_end = (phase != '0) && (tick == div_lat);
  assign cycle_end = phase_end && phase[PHASES-1];
  assign sc        = cycle_end;
  assign running   = (state != S_HALT);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= S_HALT;
      phase    <= '0;
      tick     <= '0;
      div_lat  <= '0;
      cdiv_lat <= 1'b0;
      ws       <= 1'b0;
      cycles   <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      tick     <= tick_n;
      div_lat  <= div_n;
      cdiv_lat <= cdiv_n;
      ws       <= ws_n;
      cycles   <= cycles_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    tick_n   = tick;
    div_n    = div_lat;
    cdiv_n   = cdiv_lat;
    cycles_n = cycles;
    enter    = 1'b0;
    advance  = 1'b0;
    halt     = 1'b0;

    case (state)
      S_HALT: begin
        if (!stop_edge && start_edge) begin
          state_n = S_RUN;
          enter   = 1'b1;
        end else if (!stop_edge && step_edge) begin
          state_n = S_STEP;
          enter   = 1'b1;
        end
      end
      S_RUN: begin
        advance = 1'b1;
        if (stop_edge) state_n = S_STOPPING;
      end
      S_STOPPING: begin
        advance = 1'b1;
        if (start_edge && !stop_edge) begin
          state_n = S_RUN;
        end else if (cycle_end) begin
          state_n = S_HALT;
          halt    = 1'b1;
        end
      end
      S_STEP: begin
        advance = 1'b1;
        if (start_edge) begin
          state_n = S_RUN;
        end else if (cycle_end) begin
          state_n = S_HALT;
          halt    = 1'b1;
        end
      end
      default: state_n = S_HALT;
    endcase

    if (enter) begin
      phase_n = PHASE_FIRST;
      tick_n  = '0;
      div_n   = div;
      cdiv_n  = cdiv;
    end

    // div is captured as each phase begins; cdiv only as each machine cycle begins.
    if (advance) begin
      if (phase_end) begin
        tick_n  = '0;
        phase_n = {phase[PHASES-2:0], phase[PHASES-1]};
        div_n   = div;
        if (phase[PHASES-1]) begin
          cycles_n = cycles + COUNT_WIDTH'(1);
          cdiv_n   = cdiv;
        end
      end else begin
        tick_n = tick + DIV_WIDTH'(1);
      end
    end

    if (halt) begin
      phase_n = '0;
      tick_n  = '0;
    end

    ws_n = phase_n[WS_PHASE] & cdiv_n;
  end

endmodule

`default_nettype wire

// File: doc/clock_sequencer.md
Name: clock_sequencer

Overview:
Parametrised successor to the free-running start/stop clock. Generates a multi-phase machine cycle from the single system clock, with start/stop control, single-step and a programmable phase length. Drives one-hot phase enables, the state-clock strobe (sc) and the write strobe (ws) to the datapath. Panel start/stop/step inputs are asynchronous and are synchronised internally.

Parameters:
PHASES, 4, phases per machine cycle (>=2)
DIV_WIDTH, 8, width of the phase-length divisor
WS_PHASE, 2, index of the phase in which ws is asserted (0..PHASES-1)
SYNC_STAGES, 2, synchroniser depth for nstart/nstop/step (>=2)
COUNT_WIDTH, 16, width of the machine-cycle counter

Ports:
clk  input  1  system clock; all logic on rising edge
nreset  input  1  asynchronous active-low reset
nstart  input  1  active-low run request, asynchronous; falling edge acts
nstop  input  1  active-low halt request, asynchronous; falling edge acts
step  input  1  active-high single-cycle request, asynchronous; rising edge acts
div  input  DIV_WIDTH  clk ticks per phase minus one
cdiv  input  1  write-cycle select; enables ws for the coming machine cycle
running  output  1  high while in RUN, STEP or STOPPING
phase  output  PHASES  one-hot current phase; all zero when halted
sc  output  1  one-clk pulse on the last tick of the last phase
ws  output  1  high for all of phase WS_PHASE when latched cdiv=1
cycles  output  COUNT_WIDTH  completed machine cycles; wraps to 0

Behaviour:
- Reset (nreset low, asynchronous): state HALT. running=0, phase=0, sc=0, ws=0, cycles=0. nstart/nstop synchroniser and edge flops reset to 1; step flops reset to 0. No edge is detected on release.
- Edges are detected on the last synchroniser stage against a registered copy. Latency from the first clk edge sampling the input to the acting state change is SYNC_STAGES+1 edges, inclusive.
- States: HALT, RUN, STEP, STOPPING.
- HALT: start edge -> RUN. step edge -> STEP. On entry to RUN/STEP, phase=1 (phase[0]), tick=0, cdiv latched, div latched.
- RUN:
  - tick counts 0..div_latched. At tick==div_latched, tick->0 and phase rotates left.
  - At the last phase, sc=1 for that one clk, cycles increments, and the next cycle starts at phase[0] with cdiv re-latched.
  - stop edge -> STOPPING.
- STOPPING: completes the current machine cycle, including its sc pulse and cycles increment, then HALT. The cycle is never truncated. A start edge in STOPPING returns to RUN without a gap.
- STEP: runs exactly one machine cycle, then HALT. A start edge in STEP converts it to RUN. Stop and step edges in STEP are ignored.
- Start and stop edges in the same clk: stop wins (HALT stays HALT; RUN -> STOPPING).
- Start and step edges in the same clk from HALT: start wins.
- Step or start edges in RUN are ignored.
- div is latched at tick 0 of each phase. Changes mid-phase take effect next phase. div=0 gives 1-clk phases, sc every PHASES clks.
- ws = phase[WS_PHASE] & cdiv_latched, registered and aligned with phase. cdiv changes mid-cycle have no effect.
- On HALT entry, phase=0, ws=0 and running=0 on the same edge.
- cycles wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Reset mid-cycle aborts immediately to the reset values. No sc pulse is produced.

Test Plan:
- Reset, then nstart low for 4 clks (div=1, cdiv=0, defaults) -> running and phase=4'b0001 three edges after first sampling. phase advances every 2 clks. sc pulses once per 8 clks. cycles = 1, 2, 3… ws stays 0.
- cdiv=1 while running, div=0 -> from the next cycle, ws high exactly 1 clk per 4-clk cycle, coincident with phase=4'b0100. Toggling cdiv mid-cycle does not change the current cycle.
- nstop pulse during phase[1] with div=3 -> phases 2 and 3 still complete with 4 clks each, sc fires, cycles increments once. Then phase=0 and running=0 on the next edge.
- From HALT, step pulse -> exactly one machine cycle (PHASES*(div+1) clks), one sc pulse, cycles +1, then HALT. A second step pulse gives one more cycle.
- nstart and nstop falling in the same clk from HALT -> stays HALT, running=0. In RUN, both in the same clk -> STOPPING.
- Assert nreset low mid-phase 2 -> phase, sc, ws, running and cycles are 0 immediately, with no sc pulse. After release with nstart high, the block stays HALT.
